// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a prefetch buffer.
//
// Issues word-aligned requests on an SRAM-like instruction bus. Up to MAX_OUT
// requests can be accepted and still waiting for data. Fetched words are buffered
// in a DEPTH-entry queue that feeds decode. A redirect flushes the queue,
// restarts fetch at redirect_pc and drops every response that is still owed.
// A misaligned fetch PC is never sent to the bus. Instead it is queued as an AdEL
// exception entry, and fetch halts until the next redirect.
//
// Ports
//   clk, reset                  rising-edge clock, async active-high reset
//   inst_req / inst_addr        registered bus request and its word address
//   inst_addr_ok                request accepted on this edge
//   inst_data_ok / inst_rdata   in-order read response
//   redirect / redirect_pc      flush and restart fetch
//   out_valid / out_ready       head-of-queue handshake towards decode
//   out_pc / out_inst           head entry PC and instruction (0 for exceptions)
//   out_exc / out_exccode       head entry exception flag and code (5'h04 AdEL)
//
// Handshakes: a bus request transfers on an edge where inst_req && inst_addr_ok.
// After inst_req rises, inst_req and inst_addr stay unchanged until that edge.
// A queue entry transfers to decode on an edge where out_valid && out_ready.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_exc,
  output logic [4:0]  out_exccode
);

  localparam int unsigned QW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam logic [4:0] EXC_ADEL = 5'h04;

  logic [31:0]   pc_q, pc_d;
  logic          inst_req_q, inst_req_d;
  logic [31:0]   inst_addr_q, inst_addr_d;
  logic          halted_q, halted_d;
  // Set when a redirect arrives while a request is still waiting for accept.
  // That request belongs to the old path.
  logic          stale_q, stale_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;

  logic [31:0] q_pc_mem   [DEPTH];
  logic [31:0] q_inst_mem [DEPTH];
  logic        q_exc_mem  [DEPTH];
  logic [31:0] pend_mem   [MAX_OUT];

  logic        accept, stale_accept, drop, data_push, exc_push, pop;
  logic        q_we, q_wexc;
  logic [31:0] q_wpc, q_winst, pend_pc, slots;

  always_comb begin
    accept       = inst_req_q && inst_addr_ok;
    stale_accept = accept && stale_q;
    pend_pc      = pend_mem[pend_rd_q];
    drop         = inst_data_ok && (discard_q != '0);
    data_push    = inst_data_ok && (discard_q == '0);
    // The exception entry waits until every live response has been queued, so
    // that it lands behind them in program order.
    exc_push     = !halted_q && (pc_q[1:0] != 2'b00) && (outstanding_q == discard_q) &&
                   (count_q != CW'(DEPTH)) && !redirect;
    pop          = out_valid && out_ready;

    pc_d      = pc_q;
    halted_d  = halted_q;
    stale_d   = stale_q && !accept;
    head_d    = head_q;
    tail_d    = tail_q;
    pend_wr_d = pend_wr_q;
    pend_rd_d = pend_rd_q;
    q_we      = 1'b0;
    q_wpc     = pend_pc;
    q_winst   = inst_rdata;
    q_wexc    = 1'b0;

    // A non-stale accepted address always equals pc_q.
    if (accept && !stale_q) pc_d = pc_q + 32'd4;
    if (accept) pend_wr_d = (pend_wr_q == PW'(MAX_OUT - 1)) ? '0 : pend_wr_q + PW'(1);
    if (inst_data_ok) pend_rd_d = (pend_rd_q == PW'(MAX_OUT - 1)) ? '0 : pend_rd_q + PW'(1);

    outstanding_d = outstanding_q + OW'(accept) - OW'(inst_data_ok);
    discard_d     = discard_q + OW'(stale_accept) - OW'(drop);

    if (data_push) begin
      q_we = 1'b1;
    end else if (exc_push) begin
      q_we     = 1'b1;
      q_wpc    = pc_q;
      q_winst  = '0;
      q_wexc   = 1'b1;
      halted_d = 1'b1;
    end

    if (q_we) tail_d = tail_q + QW'(1);
    if (pop)  head_d = head_q + QW'(1);
    count_d = count_q + CW'(q_we) - CW'(pop);

    if (redirect) begin
      q_we      = 1'b0;
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      pc_d      = redirect_pc;
      halted_d  = 1'b0;
      discard_d = outstanding_d;
      stale_d   = inst_req_q && !inst_addr_ok;
    end

    // Queue slots are reserved at issue time. Responses that will be discarded
    // do not need a slot.
    slots = 32'(count_d) + 32'(outstanding_d) - 32'(discard_d);
    if (inst_req_q && !inst_addr_ok) begin
      inst_req_d  = 1'b1;
      inst_addr_d = inst_addr_q;
    end else begin
      inst_req_d  = !halted_d && (pc_d[1:0] == 2'b00) &&
                    (outstanding_d < OW'(MAX_OUT)) && (slots < DEPTH);
      inst_addr_d = inst_req_d ? pc_d : inst_addr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inst_req_q    <= 1'b0;
      inst_addr_q   <= RESET_PC;
      halted_q      <= 1'b0;
      stale_q       <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      pend_wr_q     <= '0;
      pend_rd_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      inst_req_q    <= inst_req_d;
      inst_addr_q   <= inst_addr_d;
      halted_q      <= halted_d;
      stale_q       <= stale_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      pend_wr_q     <= pend_wr_d;
      pend_rd_q     <= pend_rd_d;
    end
  end

  // Payload storage has no reset. Every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (q_we) begin
      q_pc_mem[tail_q]   <= q_wpc;
      q_inst_mem[tail_q] <= q_winst;
      q_exc_mem[tail_q]  <= q_wexc;
    end
    if (accept) pend_mem[pend_wr_q] <= inst_addr_q;
  end

  assign inst_req    = inst_req_q;
  assign inst_addr   = inst_addr_q;
  assign out_valid   = (count_q != '0);
  assign out_pc      = q_pc_mem[head_q];
  assign out_inst    = q_inst_mem[head_q];
  assign out_exc     = out_valid && q_exc_mem[head_q];
  assign out_exccode = out_exc ? EXC_ADEL : 5'h00;

  a_out_max:  assert property (@(posedge clk) disable iff (reset) outstanding_q <= OW'(MAX_OUT));
  a_disc_le:  assert property (@(posedge clk) disable iff (reset) discard_q <= outstanding_q);
  a_count:    assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
  a_data_ok:  assert property (@(posedge clk) disable iff (reset) inst_data_ok |-> outstanding_q != '0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue with the default parameters
// (DEPTH=4, MAX_OUT=2). A negedge bus model answers accepted requests in order
// after a programmable latency. It also logs accepted addresses and consumed
// queue entries. The initial block drives and checks half a cycle away from
// the bus model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc;
  logic [4:0]  out_exccode;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic acc_en = 1'b1;
  int lat = 1;
  int inflight = 0;
  int max_inflight = 0;

  logic [31:0] resp_q[$];
  int          due_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] out_pc_log[$];
  logic [31:0] out_inst_log[$];
  logic [5:0]  out_ec_log[$];
  logic [31:0] exp_q[$];
  int acc_mark = 0;
  int out_mark = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc), .out_exccode(out_exccode)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[31:16]};
  endfunction

  // bus model and output monitor
  always @(negedge clk) begin
    if (reset) begin
      resp_q.delete();
      due_q.delete();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      inflight     = 0;
      max_inflight = 0;
    end else begin
      inst_addr_ok = acc_en;
      if (inst_req && acc_en) begin
        resp_q.push_back(inst_addr);
        due_q.push_back(cyc + 1 + lat);
        acc_log.push_back(inst_addr);
        inflight++;
        if (inflight > max_inflight) max_inflight = inflight;
      end
      if (due_q.size() > 0 && due_q[0] <= cyc + 1) begin
        inst_data_ok = 1'b1;
        inst_rdata   = mem_f(resp_q[0]);
        void'(resp_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
      end
      if (out_valid && out_ready) begin
        out_pc_log.push_back(out_pc);
        out_inst_log.push_back(out_inst);
        out_ec_log.push_back({out_exc, out_exccode});
        inflight--;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    acc_mark = acc_log.size();
    out_mark = out_pc_log.size();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    mark();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect    = 1'b1;
    step();
    redirect    = 1'b0;
    mark();
  endtask

  function automatic int n_acc();
    return acc_log.size() - acc_mark;
  endfunction

  function automatic int n_out();
    return out_pc_log.size() - out_mark;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    if (i < n_acc()) return acc_log[acc_mark + i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    if (i < n_out()) return out_pc_log[out_mark + i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] inst_at(input int i);
    if (i < n_out()) return out_inst_log[out_mark + i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [5:0] ec_at(input int i);
    if (i < n_out()) return out_ec_log[out_mark + i];
    return 6'bxxxxxx;
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_pc%0d", tag, i), pc_at(i), exp_q[i]);
      check($sformatf("%s_inst%0d", tag, i), inst_at(i), mem_f(exp_q[i]));
      check($sformatf("%s_exc%0d", tag, i), 32'(ec_at(i)), 32'h0);
    end
  endtask

  task automatic check_acc(input string tag, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_addr%0d", tag, i), acc_at(i), base + 32'(4 * i));
  endtask

  initial begin
    // reset values and first-fetch latency
    repeat (2) step();
    check("rst_req", 32'(inst_req), 32'h0);
    check("rst_addr", inst_addr, 32'hbfc00000);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_exc", 32'(out_exc), 32'h0);
    check("rst_code", 32'(out_exccode), 32'h0);
    reset = 1'b0;
    mark();
    step();
    check("t1_req_e1", 32'(inst_req), 32'h1);
    check("t1_addr_e1", inst_addr, 32'hbfc00000);
    check("t1_valid_e1", 32'(out_valid), 32'h0);
    step();
    check("t1_addr_e2", inst_addr, 32'hbfc00004);
    check("t1_valid_e2", 32'(out_valid), 32'h0);
    step();
    check("t1_valid_e3", 32'(out_valid), 32'h1);
    check("t1_pc_e3", out_pc, 32'hbfc00000);
    check("t1_inst_e3", out_inst, mem_f(32'hbfc00000));
    repeat (20) step();
    check("t1_rate", 32'(n_out() >= 18), 32'h1);
    check_acc("t1", 32'hbfc00000, 10);
    check_stream("t1", 32'hbfc00000, 10);

    // backpressure: queue fills to DEPTH, fetch stops, then resumes in order
    out_ready = 1'b0;
    do_reset();
    repeat (15) step();
    check("t2_accepts", 32'(n_acc()), 32'd4);
    check("t2_req", 32'(inst_req), 32'h0);
    check("t2_valid", 32'(out_valid), 32'h1);
    check("t2_pc", out_pc, 32'hbfc00000);
    check("t2_inst", out_inst, mem_f(32'hbfc00000));
    check("t2_inflight", 32'(max_inflight), 32'd4);
    out_ready = 1'b1;
    repeat (30) step();
    check_acc("t2", 32'hbfc00000, 12);
    check_stream("t2", 32'hbfc00000, 12);

    // redirect with responses in flight (3-cycle data latency)
    lat = 3;
    do_reset();
    repeat (8) step();
    do_redirect(32'h80000180);
    check("t3_valid_r0", 32'(out_valid), 32'h0);
    step();
    check("t3_valid_r1", 32'(out_valid), 32'h0);
    repeat (30) step();
    check("t3_count", 32'(n_out() >= 5), 32'h1);
    check("t3_acc0", acc_at(0), 32'h80000180);
    check_stream("t3", 32'h80000180, n_out());

    // redirect while a request waits for accept
    lat = 1;
    acc_en = 1'b0;
    do_reset();
    repeat (3) step();
    check("t4_req_pre", 32'(inst_req), 32'h1);
    check("t4_addr_pre", inst_addr, 32'hbfc00000);
    do_redirect(32'h80000180);
    check("t4_req_r0", 32'(inst_req), 32'h1);
    check("t4_addr_r0", inst_addr, 32'hbfc00000);
    step();
    check("t4_addr_r1", inst_addr, 32'hbfc00000);
    acc_en = 1'b1;
    repeat (15) step();
    check("t4_acc0", acc_at(0), 32'hbfc00000);
    check("t4_acc1", acc_at(1), 32'h80000180);
    check_stream("t4", 32'h80000180, 4);

    // misaligned redirect: one AdEL entry, no bus request, then halt
    do_redirect(32'h80000002);
    repeat (12) step();
    check("t5_accepts", 32'(n_acc()), 32'd0);
    check("t5_entries", 32'(n_out()), 32'd1);
    check("t5_pc", pc_at(0), 32'h80000002);
    check("t5_inst", inst_at(0), 32'h0);
    check("t5_exc", 32'(ec_at(0)), 32'h24);
    check("t5_req", 32'(inst_req), 32'h0);
    check("t5_valid", 32'(out_valid), 32'h0);
    do_redirect(32'h80000200);
    repeat (15) step();
    check_acc("t5b", 32'h80000200, 4);
    check_stream("t5b", 32'h80000200, 4);

    // reset in the middle of a burst
    lat = 3;
    repeat (6) step();
    reset = 1'b1;
    #1;
    check("t6_req", 32'(inst_req), 32'h0);
    check("t6_addr", inst_addr, 32'hbfc00000);
    check("t6_valid", 32'(out_valid), 32'h0);
    check("t6_exc", 32'(out_exc), 32'h0);
    step();
    step();
    reset = 1'b0;
    mark();
    step();
    check("t6_req_e1", 32'(inst_req), 32'h1);
    check("t6_addr_e1", inst_addr, 32'hbfc00000);
    repeat (20) step();
    check_acc("t6", 32'hbfc00000, 4);
    check_stream("t6", 32'hbfc00000, 4);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
